// File: rtl/ringed_squid_cpu4.sv
// ringed_squid_cpu4: 4-bit accumulator CPU driving an 11-bit nibble-addressed bus,
// one bus access per clock; HLT parks the address at 0x7FF.
`default_nettype none

module ringed_squid_cpu4 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    localparam logic [3:0] OP_LDI  = 4'h1;
    localparam logic [3:0] OP_LDA  = 4'h2;
    localparam logic [3:0] OP_STA  = 4'h3;
    localparam logic [3:0] OP_ADD  = 4'h4;
    localparam logic [3:0] OP_SUB  = 4'h5;
    localparam logic [3:0] OP_AND  = 4'h6;
    localparam logic [3:0] OP_OR   = 4'h7;
    localparam logic [3:0] OP_XOR  = 4'h8;
    localparam logic [3:0] OP_JMP  = 4'h9;
    localparam logic [3:0] OP_JZ   = 4'hA;
    localparam logic [3:0] OP_JC   = 4'hB;
    localparam logic [3:0] OP_ADDI = 4'hC;
    localparam logic [3:0] OP_NOT  = 4'hD;
    localparam logic [3:0] OP_HLT  = 4'hF;

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_OPND  = 2'd1,
        S_EXEC  = 2'd2,
        S_HALT  = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [10:0] pc_q, pc_d;
    logic [3:0]  a_q, a_d;
    logic        z_q, z_d;
    logic        c_q, c_d;
    logic [3:0]  ir_q, ir_d;
    logic [11:0] op_q, op_d;
    logic [1:0]  cnt_q, cnt_d;

    logic [3:0]  rdat;
    logic [10:0] pc_inc;
    logic [11:0] op_shift;
    logic [4:0]  add5;
    logic [4:0]  sub5;
    logic        acc_we;
    logic [3:0]  acc_res;
    logic        jmp_taken;
    logic [10:0] addr;
    logic        rw;
    logic        unused_ok;

    assign unused_ok = &{1'b0, ena, ui_in, uio_in[7:4]};

    assign rdat     = uio_in[3:0];
    assign pc_inc   = pc_q + 11'd1;
    assign op_shift = {op_q[7:0], rdat};
    assign add5     = {1'b0, a_q} + {1'b0, rdat};
    assign sub5     = {1'b0, a_q} - {1'b0, rdat};

    always_comb begin
        jmp_taken = 1'b0;
        case (ir_q)
            OP_JMP:  jmp_taken = 1'b1;
            OP_JZ:   jmp_taken = z_q;
            OP_JC:   jmp_taken = c_q;
            default: jmp_taken = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_FETCH;
            pc_q    <= 11'd0;
            a_q     <= 4'd0;
            z_q     <= 1'b0;
            c_q     <= 1'b0;
            ir_q    <= 4'd0;
            op_q    <= 12'd0;
            cnt_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            a_q     <= a_d;
            z_q     <= z_d;
            c_q     <= c_d;
            ir_q    <= ir_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        c_d     = c_q;
        ir_d    = ir_q;
        op_d    = op_q;
        cnt_d   = cnt_q;
        acc_we  = 1'b0;
        acc_res = a_q;

        case (state_q)
            S_FETCH: begin
                ir_d  = rdat;
                pc_d  = pc_inc;
                cnt_d = 2'd0;
                if (rdat == OP_HLT) begin
                    state_d = S_HALT;
                end else if (rdat >= OP_LDI && rdat <= OP_ADDI) begin
                    state_d = S_OPND;
                end else if (rdat == OP_NOT) begin
                    acc_we  = 1'b1;
                    acc_res = ~a_q;
                end
            end
            S_OPND: begin
                op_d  = op_shift;
                pc_d  = pc_inc;
                cnt_d = cnt_q + 2'd1;
                if (ir_q == OP_LDI) begin
                    acc_we  = 1'b1;
                    acc_res = rdat;
                    state_d = S_FETCH;
                end else if (ir_q == OP_ADDI) begin
                    acc_we  = 1'b1;
                    acc_res = add5[3:0];
                    c_d     = add5[4];
                    state_d = S_FETCH;
                end else if (cnt_q == 2'd2) begin
                    // Third address nibble: jumps resolve here, data ops need a bus cycle
                    if (ir_q >= OP_JMP) begin
                        if (jmp_taken) begin
                            pc_d = op_shift[10:0];
                        end
                        state_d = S_FETCH;
                    end else begin
                        state_d = S_EXEC;
                    end
                end
            end
            S_EXEC: begin
                state_d = S_FETCH;
                case (ir_q)
                    OP_LDA: begin acc_we = 1'b1; acc_res = rdat; end
                    OP_ADD: begin acc_we = 1'b1; acc_res = add5[3:0]; c_d = add5[4]; end
                    OP_SUB: begin acc_we = 1'b1; acc_res = sub5[3:0]; c_d = ~sub5[4]; end
                    OP_AND: begin acc_we = 1'b1; acc_res = a_q & rdat; end
                    OP_OR:  begin acc_we = 1'b1; acc_res = a_q | rdat; end
                    OP_XOR: begin acc_we = 1'b1; acc_res = a_q ^ rdat; end
                    default: ;
                endcase
            end
            S_HALT: state_d = S_HALT;
            default: state_d = S_FETCH;
        endcase

        a_d = acc_we ? acc_res : a_q;
        z_d = acc_we ? (acc_res == 4'd0) : z_q;
    end

    always_comb begin
        addr = pc_q;
        rw   = 1'b0;
        case (state_q)
            S_EXEC: begin
                addr = op_q[10:0];
                rw   = (ir_q == OP_STA);
            end
            S_HALT:  addr = 11'h7FF;
            default: ;
        endcase
    end

    assign uo_out  = {rw, addr[10:4]};
    assign uio_out = {addr[3:0], (rw ? a_q : 4'h0)};
    assign uio_oe  = rw ? 8'hFF : 8'hF0;

endmodule

`default_nettype wire

// File: tb/tb_ringed_squid_cpu4.sv
// Bench for ringed_squid_cpu4: nibble RAM on the bus, ISA-level model producing the
// expected per-cycle bus trace, plus hand-computed literal expectations.
`default_nettype none

module tb_ringed_squid_cpu4;

    localparam int LOGN = 2100;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       ena   = 1'b1;
    logic [7:0] ui_in = 8'h00;
    logic [7:0] uio_in;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    always #5 clk = ~clk;

    ringed_squid_cpu4 dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .ui_in   (ui_in),
        .uio_in  (uio_in),
        .uo_out  (uo_out),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    // Program image plus a write overlay tagged with a test generation number
    logic [3:0] prog [2048];
    logic [3:0] wmem [2048];
    int         wgen [2048];
    int         cur_gen = 1;

    wire [10:0] bus_addr = {uo_out[6:0], uio_out[7:4]};
    assign uio_in = {4'h0, (wgen[bus_addr] == cur_gen) ? wmem[bus_addr] : prog[bus_addr]};

    always @(negedge clk) begin
        if (uo_out[7]) begin
            wmem[bus_addr] <= uio_out[3:0];
            wgen[bus_addr] <= cur_gen;
        end
    end

    int errors = 0;
    int checks = 0;
    logic [23:0] blog [LOGN];
    int nlog = 0;

    logic [3:0]  mm [2048];
    logic [10:0] m_pc;
    logic [3:0]  m_a;
    bit          m_z, m_c, m_halt;
    logic [23:0] exp_q [$];

    function automatic logic [3:0] memrd(input logic [10:0] a);
        return (wgen[a] == cur_gen) ? wmem[a] : prog[a];
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic push(input logic [10:0] a, input bit w, input logic [3:0] d);
        exp_q.push_back({w, a, d, (w ? 8'hFF : 8'hF0)});
    endtask

    task automatic fetch_nib(output logic [3:0] v);
        push(m_pc, 1'b0, 4'h0);
        v    = mm[m_pc];
        m_pc = m_pc + 11'd1;
    endtask

    task automatic model_gen(input int n);
        logic [3:0]  opc, n1, n2, n3, v;
        logic [10:0] ea;
        int          r;
        while (exp_q.size() < n) begin
            if (m_halt) begin
                push(11'h7FF, 1'b0, 4'h0);
            end else begin
                fetch_nib(opc);
                if (opc == 4'hF) begin
                    m_halt = 1'b1;
                end else if (opc == 4'hD) begin
                    m_a = ~m_a;
                    m_z = (m_a == 4'h0);
                end else if (opc == 4'h1 || opc == 4'hC) begin
                    fetch_nib(v);
                    if (opc == 4'h1) begin
                        m_a = v;
                    end else begin
                        r   = m_a + v;
                        m_c = (r > 15);
                        m_a = r[3:0];
                    end
                    m_z = (m_a == 4'h0);
                end else if (opc >= 4'h2 && opc <= 4'hB) begin
                    fetch_nib(n1);
                    fetch_nib(n2);
                    fetch_nib(n3);
                    ea = {n1[2:0], n2, n3};
                    if (opc == 4'h9 || (opc == 4'hA && m_z) || (opc == 4'hB && m_c)) begin
                        m_pc = ea;
                    end else if (opc == 4'h3) begin
                        push(ea, 1'b1, m_a);
                        mm[ea] = m_a;
                    end else if (opc <= 4'h8) begin
                        push(ea, 1'b0, 4'h0);
                        v = mm[ea];
                        case (opc)
                            4'h2: m_a = v;
                            4'h4: begin r = m_a + v; m_c = (r > 15); m_a = r[3:0]; end
                            4'h5: begin m_c = (m_a >= v); r = m_a - v; m_a = r[3:0]; end
                            4'h6: m_a = m_a & v;
                            4'h7: m_a = m_a | v;
                            default: m_a = m_a ^ v;
                        endcase
                        m_z = (m_a == 4'h0);
                    end
                end
            end
        end
    endtask

    // Called at a negedge; samples the current cycle then advances one cycle
    task automatic run_cycles(input int n, input bit en);
        logic [23:0] act, e;
        for (int i = 0; i < n; i++) begin
            act = {uo_out[7], bus_addr, uio_out[3:0], uio_oe};
            if (nlog < LOGN) begin
                blog[nlog] = act;
                nlog++;
            end
            if (en) begin
                if (exp_q.size() == 0) begin
                    errors++;
                    checks++;
                    $display("FAIL model underrun at cycle %0d: got %h expected a model entry", i + 1, act);
                end else begin
                    e = exp_q.pop_front();
                    chk($sformatf("bus cycle %0d", i + 1), act, e);
                end
            end
            @(negedge clk);
        end
    endtask

    task automatic new_test();
        cur_gen++;
        for (int i = 0; i < 2048; i++) begin
            prog[i] = 4'h0;
            mm[i]   = 4'h0;
        end
    endtask

    task automatic poke(input logic [10:0] a, input logic [3:0] v);
        prog[a] = v;
        mm[a]   = v;
    endtask

    task automatic put_seq(input logic [10:0] base, input logic [63:0] s, input int n);
        for (int i = 0; i < n; i++) begin
            poke(base + 11'(i), s[4*(n-1-i) +: 4]);
        end
    endtask

    task automatic reset_dut();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("reset bus state", {uo_out[7], bus_addr, uio_out[3:0], uio_oe},
            {1'b0, 11'h000, 4'h0, 8'hF0});
        @(negedge clk);
        rst_n  = 1'b1;
        m_pc   = 11'd0;
        m_a    = 4'd0;
        m_z    = 1'b0;
        m_c    = 1'b0;
        m_halt = 1'b0;
        exp_q.delete();
        nlog = 0;
    endtask

    task automatic run_model(input int n);
        model_gen(n);
        run_cycles(n, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not reach the summary");
        $fatal(1, "timeout");
    end

    initial begin
        logic wr_seen;

        // All-NOP memory: sequential fetch addresses with wrap after 0x7FF
        new_test();
        reset_dut();
        run_model(2052);
        chk("nop addr 0x7FF", blog[2047][22:12], 11'h7FF);
        chk("nop wrap to 0", blog[2048][22:12], 11'h000);

        // LDI 5; STA 0x040; HLT
        new_test();
        put_seq(11'h000, 64'h153040F, 7);
        reset_dut();
        run_model(12);
        chk("sta write cycle 7", blog[6], {1'b1, 11'h040, 4'h5, 8'hFF});
        chk("halt parks at 7FF", blog[8][22:12], 11'h7FF);
        chk("mem 040 after sta", memrd(11'h040), 4'h5);

        // LDI 9; ADDI 8 (carry); STA 0x050; JC 0x030 taken skips STA 0x051
        new_test();
        put_seq(11'h000, 64'h19C83050B030, 12);
        put_seq(11'h00C, 64'h173051F, 7);
        poke(11'h030, 4'hF);
        reset_dut();
        run_model(25);
        chk("addi result stored", memrd(11'h050), 4'h1);
        chk("jc taken skips store", memrd(11'h051), 4'h0);

        // LDA 0x100; SUB 0x101; JZ 0x020 -> STA 0x060; JC 0x030 -> LDI 4; STA 0x061
        new_test();
        poke(11'h100, 4'h3);
        poke(11'h101, 4'h3);
        poke(11'h060, 4'h9);
        put_seq(11'h000, 64'h21005101A020F, 13);
        put_seq(11'h020, 64'h3060B030F, 9);
        put_seq(11'h030, 64'h143061F, 7);
        reset_dut();
        run_model(45);
        chk("jz lands at 020", blog[14][22:12], 11'h020);
        chk("sub result zero", memrd(11'h060), 4'h0);
        chk("sub carry set", memrd(11'h061), 4'h4);

        // LDI 0; NOT; STA 0x070; JC 0x030 untaken -> LDI 2; STA 0x071
        new_test();
        put_seq(11'h000, 64'h10D3070B030, 11);
        put_seq(11'h00B, 64'h123071F, 7);
        poke(11'h030, 4'hF);
        reset_dut();
        run_model(28);
        chk("not write cycle", blog[7], {1'b1, 11'h070, 4'hF, 8'hFF});
        chk("not result F", memrd(11'h070), 4'hF);
        chk("jc untaken falls through", memrd(11'h071), 4'h2);

        // Reset sampled at the edge that would enter the STA data cycle
        new_test();
        put_seq(11'h000, 64'h153040F, 7);
        reset_dut();
        run_cycles(5, 1'b0);
        rst_n = 1'b0;
        run_cycles(1, 1'b0);
        rst_n = 1'b1;
        run_cycles(3, 1'b0);
        wr_seen = 1'b0;
        for (int i = 0; i < 9; i++) wr_seen = wr_seen | blog[i][23];
        chk("last operand addr", blog[5][22:12], 11'h005);
        chk("no write after abort", wr_seen, 1'b0);
        chk("fetch at 0 after reset", blog[6], {1'b0, 11'h000, 4'h0, 8'hF0});
        chk("second fetch addr", blog[7][22:12], 11'h001);
        chk("mem 040 untouched", memrd(11'h040), 4'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
